// File: rtl/onchip_mem_wiper.sv
// onchip_mem_wiper: Avalon-MM master that fills a word range of the on-chip
// RAM with a latched pattern and can optionally read the range back to check it.
//
// state  | meaning
// IDLE   | waiting for start; range check happens on the start cycle
// WRITE  | one pattern write per cycle, base .. base+num-1
// VERIFY | one read per cycle; each word is compared one cycle after its read
// DONE   | one-cycle done pulse, then back to IDLE
`timescale 1ns/1ps

module onchip_mem_wiper #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 6500
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_words,
    input  logic [DATA_W-1:0]   pattern,
    input  logic                verify_en,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_num;
    logic [ADDR_W:0]     r_remain;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic [DATA_W-1:0]   r_pattern;
    logic                r_verify;
    logic                r_rd_pend;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [ADDR_W-1:0]   r_err_addr;
    logic                r_cs;
    logic                r_we;

    // One extra bit beyond the address+1 width so the end-of-range sum cannot wrap.
    logic [ADDR_W+1:0]   w_end;
    logic                w_range_bad;
    logic                w_mismatch;

    assign w_end       = {2'b00, base_addr} + {1'b0, num_words};
    assign w_range_bad = (w_end > (ADDR_W+2)'(DEPTH));
    // r_rd_pend marks that mem_readdata this cycle belongs to r_cmp_addr.
    assign w_mismatch  = r_rd_pend && (mem_readdata != r_pattern);

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_addr       = r_err_addr;
    assign mem_address    = r_addr;
    assign mem_chipselect = r_cs;
    assign mem_write      = r_we;
    assign mem_writedata  = r_pattern;
    assign mem_byteenable = {BE_W{1'b1}};
    assign mem_clken      = 1'b1;

    // Sequencer: state, RAM strobes, address walk and verify compare pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_remain   <= '0;
            r_addr     <= '0;
            r_cmp_addr <= '0;
            r_pattern  <= '0;
            r_verify   <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_num     <= num_words;
                        r_pattern <= pattern;
                        r_verify  <= verify_en;
                        r_error   <= 1'b0;
                        if (num_words == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_range_bad) begin
                            r_error    <= 1'b1;
                            r_err_addr <= base_addr;
                        end else begin
                            r_state  <= S_WRITE;
                            r_busy   <= 1'b1;
                            r_cs     <= 1'b1;
                            r_we     <= 1'b1;
                            r_addr   <= base_addr;
                            r_remain <= num_words - (ADDR_W+1)'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cs    <= 1'b0;
                        r_we    <= 1'b0;
                    end else if (r_remain == '0) begin
                        if (r_verify) begin
                            r_state   <= S_VERIFY;
                            r_we      <= 1'b0;
                            r_addr    <= r_base;
                            r_remain  <= r_num - (ADDR_W+1)'(1);
                            r_rd_pend <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_cs    <= 1'b0;
                            r_we    <= 1'b0;
                        end
                    end else begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_remain <= r_remain - (ADDR_W+1)'(1);
                    end
                end
                S_VERIFY: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_cs      <= 1'b0;
                        r_rd_pend <= 1'b0;
                    end else if (w_mismatch) begin
                        r_state    <= S_IDLE;
                        r_error    <= 1'b1;
                        r_err_addr <= r_cmp_addr;
                        r_busy     <= 1'b0;
                        r_cs       <= 1'b0;
                        r_rd_pend  <= 1'b0;
                    end else if (r_rd_pend && !r_cs) begin
                        // final word compared clean and no read is outstanding
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_rd_pend <= 1'b0;
                    end else begin
                        r_rd_pend  <= r_cs;
                        r_cmp_addr <= r_addr;
                        if (r_cs) begin
                            if (r_remain == '0) begin
                                r_cs <= 1'b0;
                            end else begin
                                r_addr   <= r_addr + ADDR_W'(1);
                                r_remain <= r_remain - (ADDR_W+1)'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_wiper.sv
// Testbench for onchip_mem_wiper: model RAM plus an access scoreboard; each
// scenario task checks busy/done/error timing inline.
`timescale 1ns/1ps

module tb_onchip_mem_wiper;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 6500;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [DW-1:0] pattern;
    logic          verify_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata;

    always #5 clk = ~clk;

    onchip_mem_wiper #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words), .pattern(pattern),
        .verify_en(verify_en), .busy(busy), .done(done), .error(error),
        .err_addr(err_addr), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Model RAM with one-cycle read latency and a corruption hook.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          corrupt_req = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
        if (corrupt_req) ram[corrupt_addr] <= ram[corrupt_addr] ^ 32'h0000_0100;
    end

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt = 0;
    int   t0 = 0;
    int   mon_cyc;
    exp_t mon_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard monitor: every RAM access must match the next expected one.
    always @(negedge clk) begin
        if (reset_n && mem_chipselect) begin
            mon_cyc = edge_cnt - t0 + 1;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: access at cycle %0d addr %h we %b, required no access",
                         mon_cyc, mem_address, mem_write);
            end else begin
                mon_e = sb.pop_front();
                if (mon_cyc !== mon_e.cyc || mem_write !== mon_e.we || mem_address !== mon_e.addr ||
                    (mon_e.we && mem_writedata !== mon_e.data) || mem_byteenable !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sb_access: got cyc %0d we %b addr %h data %h be %h, required cyc %0d we %b addr %h data %h be f",
                             mon_cyc, mem_write, mem_address, mem_writedata, mem_byteenable,
                             mon_e.cyc, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push_op(input logic [AW-1:0] b, input int n, input logic [DW-1:0] p, input logic v);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = i + 1; e.we = 1'b1; e.addr = AW'(b + i); e.data = p;
            sb.push_back(e);
        end
        if (v) begin
            for (int i = 0; i < n; i++) begin
                e.cyc = n + 1 + i; e.we = 1'b0; e.addr = AW'(b + i); e.data = '0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_start(input logic [AW-1:0] b, input int n, input logic [DW-1:0] p,
                               input logic v, input logic ab);
        @(negedge clk);
        base_addr = b; num_words = (AW+1)'(n); pattern = p; verify_en = v;
        start = 1'b1; abort = ab;
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; verify_en = 1'b0;
        base_addr = '0; num_words = '0; pattern = '0;
        #12;
        n_tests++;
        if ({busy, done, error, mem_chipselect, mem_write, mem_clken} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b, required 000001",
                     {busy, done, error, mem_chipselect, mem_write, mem_clken});
        end
        n_tests++;
        if (err_addr !== '0) begin n_fail++; $display("FAIL reset_err_addr: got %h, required 0", err_addr); end
        n_tests++;
        if (mem_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", mem_address); end
        n_tests++;
        if (mem_writedata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", mem_writedata); end
        n_tests++;
        if (mem_byteenable !== 4'hF) begin n_fail++; $display("FAIL reset_be: got %h, required f", mem_byteenable); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        push_op(13'h100, 4, 32'h0, 1'b0);
        drive_start(13'h100, 4, 32'h0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            n_tests++;
            if (busy !== (c <= 4) || done !== (c == 5)) begin
                n_fail++;
                $display("FAIL fill_timing: cycle %0d got busy %b done %b, required busy %b done %b",
                         c, busy, done, (c <= 4), (c == 5));
            end
            if (c == 2) begin
                base_addr = 13'h500; num_words = 14'd3; pattern = 32'hFFFF_FFFF; start = 1'b1;
            end
        end
        n_tests++;
        if (sb.size() != 0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_end: got pending %0d error %b, required 0 0", sb.size(), error);
        end
    endtask

    task automatic test_verify_pass();
        push_op(13'h0, 3, 32'hA5A5_A5A5, 1'b1);
        drive_start(13'h0, 3, 32'hA5A5_A5A5, 1'b1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== (c <= 7) || done !== (c == 8) || error !== 1'b0) begin
                n_fail++;
                $display("FAIL verify_pass: cycle %0d got busy %b done %b error %b, required %b %b 0",
                         c, busy, done, error, (c <= 7), (c == 8));
            end
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL verify_pass_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_verify_fail();
        push_op(13'h0, 3, 32'hA5A5_A5A5, 1'b1);
        drive_start(13'h0, 3, 32'hA5A5_A5A5, 1'b1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 5) corrupt_req = 1'b0;
            n_tests++;
            if (busy !== (c <= 6) || done !== 1'b0 || error !== (c >= 7)) begin
                n_fail++;
                $display("FAIL verify_fail: cycle %0d got busy %b done %b error %b, required %b 0 %b",
                         c, busy, done, error, (c <= 6), (c >= 7));
            end
            if (c == 7) begin
                n_tests++;
                if (err_addr !== 13'd1) begin
                    n_fail++; $display("FAIL verify_err_addr: got %h, required 1", err_addr);
                end
            end
            if (c == 4) begin
                corrupt_addr = 13'd1; corrupt_req = 1'b1;
            end
        end
        n_tests++;
        if (sb.size() != 0 || mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL verify_fail_end: got pending %0d cs %b, required 0 0", sb.size(), mem_chipselect);
        end
    endtask

    task automatic test_boundary();
        push_op(13'd6499, 1, 32'h1234_5678, 1'b0);
        drive_start(13'd6499, 1, 32'h1234_5678, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== (c == 1) || done !== (c == 2) || error !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_ok: cycle %0d got busy %b done %b error %b, required %b %b 0",
                         c, busy, done, error, (c == 1), (c == 2));
            end
        end
        drive_start(13'd6499, 2, 32'h1234_5678, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (error !== 1'b1 || err_addr !== 13'd6499 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_over: cycle %0d got error %b err_addr %0d busy %b done %b, required 1 6499 0 0",
                         c, error, err_addr, busy, done);
            end
        end
    endtask

    task automatic test_zero();
        drive_start(13'h40, 0, 32'h0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (done !== (c == 1) || error !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len: cycle %0d got done %b error %b busy %b, required %b 0 0",
                         c, done, error, busy, (c == 1));
            end
        end
    endtask

    task automatic test_abort();
        push_op(13'h20, 2, 32'hDEAD_BEEF, 1'b0);
        drive_start(13'h20, 10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 3) abort = 1'b0;
            n_tests++;
            if (busy !== (c <= 2) || done !== 1'b0 || error !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_write: cycle %0d got busy %b done %b error %b, required %b 0 0",
                         c, busy, done, error, (c <= 2));
            end
            if (c == 2) abort = 1'b1;
        end
        // start and abort together in IDLE: start wins
        push_op(13'h30, 2, 32'h0F0F_0F0F, 1'b0);
        drive_start(13'h30, 2, 32'h0F0F_0F0F, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== (c <= 2) || done !== (c == 3)) begin
                n_fail++;
                $display("FAIL start_abort: cycle %0d got busy %b done %b, required %b %b",
                         c, busy, done, (c <= 2), (c == 3));
            end
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL abort_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        push_op(13'h200, 10, 32'h5555_AAAA, 1'b0);
        drive_start(13'h200, 10, 32'h5555_AAAA, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, error, mem_chipselect, mem_write} !== 5'b0 || mem_address !== '0 ||
            mem_writedata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got ctl %b addr %h wdata %h, required 00000 0 0",
                     {busy, done, error, mem_chipselect, mem_write}, mem_address, mem_writedata);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        push_op(13'h10, 2, 32'hC3C3_3C3C, 1'b1);
        drive_start(13'h10, 2, 32'hC3C3_3C3C, 1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== (c <= 5) || done !== (c == 6) || error !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset: cycle %0d got busy %b done %b error %b, required %b %b 0",
                         c, busy, done, error, (c <= 5), (c == 6));
            end
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL after_reset_pending: got %0d, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_verify_pass();
        test_verify_fail();
        test_boundary();
        test_zero();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
